// File: rtl/pagerank_graph_loader.sv
// Builds the pageRank adjacency matrix from a serial edge stream, then derives
// per-node weights 1/outdeg (Q0.WIDTH) with a bit-serial restoring divider.
module pagerank_graph_loader #(
  parameter int N     = 64,
  parameter int WIDTH = 16,
  parameter int IDW   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 edge_valid,
  output logic                 edge_ready,
  input  logic [IDW-1:0]       edge_src,
  input  logic [IDW-1:0]       edge_dst,
  input  logic                 edge_last,
  output logic [N*N-1:0]       adj,
  output logic [N*WIDTH-1:0]   nodeWeight,
  output logic                 graph_valid,
  output logic                 pr_start,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WEIGHT = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = $clog2(N * N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [IDW-1:0] K_LAST   = IDW'(N - 1);
  localparam logic [IDW-1:0] K_ONE    = IDW'(1);
  localparam logic [IDW:0]   DEG_ONE  = (IDW+1)'(1);

  state_t state, state_nxt;

  logic [IDW:0]     deg [N];
  logic [IDW-1:0]   k;
  logic [CW-1:0]    cnt;
  logic [IDW:0]     rem;
  logic [WIDTH-1:0] quo;

  logic             accept;
  logic             ids_ok;
  logic [AW-1:0]    adj_idx;
  logic             div_bit;
  logic [IDW+1:0]   rem_sh;
  logic [IDW+1:0]   d_ext;
  logic             ge;
  logic [IDW:0]     rem_nxt;
  logic [WIDTH:0]   q_full;
  logic [WIDTH-1:0] weight;
  logic             node_end;
  logic             last_node;

  // Handshake: an edge transfers on a rising clk edge when edge_valid and
  // edge_ready are both high and clear is low; edge_ready depends only on state,
  // and the source holds src/dst/last stable until the transfer happens.
  assign edge_ready  = (state == LOAD);
  assign busy        = (state == WEIGHT);
  assign graph_valid = (state == DONE);
  assign dbg_state   = state;
  assign accept      = edge_valid & edge_ready & ~clear;

  generate
    if (N == (1 << IDW)) begin : g_ids_full
      assign ids_ok = 1'b1;
    end else begin : g_ids_chk
      assign ids_ok = (int'(edge_src) < N) && (int'(edge_dst) < N);
    end
  endgenerate

  assign adj_idx = AW'(int'(edge_src) * N + int'(edge_dst));

  // Dividend is 2^WIDTH: a single 1 shifted in first, then WIDTH zeros.
  always_comb begin
    div_bit   = (cnt == '0);
    rem_sh    = {rem, div_bit};
    d_ext     = {1'b0, deg[k]};
    ge        = (rem_sh >= d_ext);
    rem_nxt   = ge ? (IDW+1)'(rem_sh - d_ext) : rem_sh[IDW:0];
    q_full    = {quo, ge};
    node_end  = (cnt == CNT_LAST);
    last_node = (k == K_LAST);
    if (deg[k] == '0)
      weight = '0;
    else if (q_full[WIDTH])
      weight = '1;
    else
      weight = q_full[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (accept && edge_last) state_nxt = WEIGHT;
        WEIGHT:  if (node_end && last_node) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adj        <= '0;
      nodeWeight <= '0;
      for (int i = 0; i < N; i++) deg[i] <= '0;
      k          <= '0;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      pr_start   <= 1'b0;
    end else if (clear) begin
      adj        <= '0;
      nodeWeight <= '0;
      for (int i = 0; i < N; i++) deg[i] <= '0;
      k          <= '0;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      pr_start   <= 1'b0;
    end else begin
      pr_start <= 1'b0;
      case (state)
        LOAD: begin
          // Only a first-time edge raises the degree, so duplicates are free.
          if (accept && ids_ok && !adj[adj_idx]) begin
            adj[adj_idx]  <= 1'b1;
            deg[edge_src] <= deg[edge_src] + DEG_ONE;
          end
          if (accept && edge_last) begin
            k   <= '0;
            cnt <= '0;
            rem <= '0;
            quo <= '0;
          end
        end
        WEIGHT: begin
          if (node_end) begin
            nodeWeight[int'(k)*WIDTH +: WIDTH] <= weight;
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            k   <= k + K_ONE;
            if (last_node) pr_start <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
            rem <= rem_nxt;
            quo <= {quo[WIDTH-2:0], ge};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_graph_loader.sv
// Bench for pagerank_graph_loader: graph tables drive edges, a reference model
// queues expected weights, and hand sequences cover clear, backpressure and reset.
module tb_pagerank_graph_loader;

  localparam int N     = 64;
  localparam int WIDTH = 16;
  localparam int IDW   = 6;
  localparam int WEIGHT_CYCLES = N * (WIDTH + 1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 clear = 1'b0;
  logic                 edge_valid = 1'b0;
  logic                 edge_ready;
  logic [IDW-1:0]       edge_src = '0;
  logic [IDW-1:0]       edge_dst = '0;
  logic                 edge_last = 1'b0;
  logic [N*N-1:0]       adj;
  logic [N*WIDTH-1:0]   nodeWeight;
  logic                 graph_valid;
  logic                 pr_start;
  logic                 busy;
  logic [1:0]           dbg_state;

  pagerank_graph_loader #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
    .adj(adj), .nodeWeight(nodeWeight),
    .graph_valid(graph_valid), .pr_start(pr_start), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [IDW-1:0] src;
    logic [IDW-1:0] dst;
    logic           last;
  } edge_t;

  typedef struct {
    int               node;
    logic [WIDTH-1:0] w;
  } wchk_t;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  logic [N*N-1:0]   m_adj;
  int               m_deg [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_adj(input string name);
    int diffs = 0;
    int first = -1;
    for (int i = 0; i < N*N; i++)
      if (adj[i] !== m_adj[i]) begin
        diffs++;
        if (first < 0) first = i;
      end
    n_vec++;
    if (diffs != 0) begin
      n_err++;
      $display("FAIL %s act_ones=%0d exp_ones=%0d diff_bits=%0d first_diff=%0d",
               name, $countones(adj), $countones(m_adj), diffs, first);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_w(input int d);
    if (d == 0) return '0;
    if (d == 1) return '1;
    return WIDTH'((1 << WIDTH) / d);
  endfunction

  task automatic model_reset();
    m_adj = '0;
    for (int i = 0; i < N; i++) m_deg[i] = 0;
    exp_q.delete();
  endtask

  // driver tasks
  task automatic send_edge(input logic [IDW-1:0] s, input logic [IDW-1:0] d, input logic l);
    int t = 0;
    int idx;
    edge_src   = s;
    edge_dst   = d;
    edge_last  = l;
    edge_valid = 1'b1;
    while (!edge_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!edge_ready) begin
      chk("edge_ready_timeout", 32'(edge_ready), 32'd1);
    end else begin
      idx = int'(s) * N + int'(d);
      if (!m_adj[idx]) begin
        m_adj[idx] = 1'b1;
        m_deg[s]++;
      end
      if (l)
        for (int i = 0; i < N; i++) exp_q.push_back(ref_w(m_deg[i]));
    end
    @(posedge clk); #1;
    edge_valid = 1'b0;
    edge_last  = 1'b0;
  endtask

  task automatic send_graph(input edge_t g[$]);
    foreach (g[i]) send_edge(g[i].src, g[i].dst, g[i].last);
  endtask

  task automatic wait_done(input bit bp);
    int  busy_cnt = 0;
    int  pulses   = 0;
    int  cyc      = 0;
    bit  prev_gv  = 1'b0;
    while (cyc < 3000) begin
      if (busy) busy_cnt++;
      if (bp && cyc == 5) chk("bp_ready_in_weight", 32'(edge_ready), 32'd0);
      if (pr_start) begin
        pulses++;
        chk("pr_start_with_gv", 32'(graph_valid), 32'd1);
        chk("pr_start_first_done", 32'(prev_gv), 32'd0);
      end
      if (graph_valid) break;
      prev_gv = graph_valid;
      @(posedge clk); #1;
      cyc++;
    end
    chk("graph_valid_reached", 32'(graph_valid), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'(WEIGHT_CYCLES));
    repeat (3) begin
      @(posedge clk); #1;
      if (pr_start) pulses++;
    end
    chk("graph_valid_held", 32'(graph_valid), 32'd1);
    chk("pr_start_pulses", 32'(pulses), 32'd1);
    if (bp) chk("bp_ready_in_done", 32'(edge_ready), 32'd0);
    chk_adj("adj_final");
    for (int i = 0; i < N; i++) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 32'd0, 32'd1);
        break;
      end
      chk($sformatf("weight[%0d]", i), 32'(nodeWeight[i*WIDTH +: WIDTH]), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic check_table(input string tag, input wchk_t t[$]);
    foreach (t[i])
      chk($sformatf("%s_w[%0d]", tag, t[i].node),
          32'(nodeWeight[t[i].node*WIDTH +: WIDTH]), 32'(t[i].w));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ready"}, 32'(edge_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_gv"}, 32'(graph_valid), 32'd0);
    chk({tag, "_pr_start"}, 32'(pr_start), 32'd0);
    chk({tag, "_adj_ones"}, 32'($countones(adj)), 32'd0);
    chk({tag, "_weight_zero"}, 32'(nodeWeight == '0), 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_cleared("clear");
    chk("clear_state", 32'(dbg_state), 32'd0);
    model_reset();
  endtask

  edge_t g_small[$];
  edge_t g_deg[$];
  edge_t g_wide[$];
  wchk_t c_small[$];
  wchk_t c_deg[$];
  wchk_t c_wide[$];
  int    small_bits[$];

  task automatic check_small();
    wait_done(1'b0);
    check_table("small", c_small);
    foreach (small_bits[i])
      chk($sformatf("small_adj[%0d]", small_bits[i]), 32'(adj[small_bits[i]]), 32'd1);
    chk("small_adj_ones", 32'($countones(adj)), 32'd5);
  endtask

  initial begin
    g_small = '{'{6'd0, 6'd1, 1'b0}, '{6'd0, 6'd29, 1'b0}, '{6'd0, 6'd63, 1'b0},
                '{6'd1, 6'd0, 1'b0}, '{6'd1, 6'd2, 1'b1}};
    c_small = '{'{0, 16'h5555}, '{1, 16'h8000}, '{2, 16'h0000}, '{63, 16'h0000}};
    small_bits = '{1, 29, 63, 64, 66};
    g_deg = '{'{6'd6, 6'd2, 1'b0}, '{6'd6, 6'd9, 1'b0}, '{6'd6, 6'd22, 1'b0},
              '{6'd6, 6'd9, 1'b0}, '{6'd6, 6'd32, 1'b0}, '{6'd7, 6'd8, 1'b0},
              '{6'd5, 6'd5, 1'b1}};
    c_deg = '{'{6, 16'h4000}, '{7, 16'hFFFF}, '{5, 16'hFFFF}, '{9, 16'h0000}};
    for (int d = 0; d < N; d++) g_wide.push_back('{6'd40, 6'(d), 1'b0});
    g_wide.push_back('{6'd41, 6'd1, 1'b0});
    g_wide.push_back('{6'd41, 6'd2, 1'b0});
    g_wide.push_back('{6'd41, 6'(N - 1), 1'b1});
    c_wide = '{'{40, 16'h0400}, '{41, 16'h5555}, '{39, 16'h0000}};
    model_reset();

    // reset held with an edge presented: nothing may be captured
    edge_valid = 1'b1;
    edge_src   = 6'd3;
    edge_dst   = 6'd4;
    edge_last  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("in_reset");
    edge_valid = 1'b0;
    edge_last  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_cleared("post_reset");
    chk("post_reset_state", 32'(dbg_state), 32'd0);

    // small graph
    send_graph(g_small);
    check_small();
    do_clear();

    // degree rules, with edge_valid held through WEIGHT and DONE
    send_graph(g_deg);
    edge_src   = 6'd3;
    edge_dst   = 6'd4;
    edge_last  = 1'b1;
    edge_valid = 1'b1;
    wait_done(1'b1);
    check_table("deg", c_deg);
    edge_valid = 1'b0;
    edge_last  = 1'b0;
    do_clear();

    // maximum out-degree
    send_graph(g_wide);
    wait_done(1'b0);
    check_table("wide", c_wide);
    do_clear();

    // clear while node 10 is being divided
    send_graph(g_small);
    repeat (10 * (WIDTH + 1) + 5) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_w0_written", 32'(nodeWeight[0 +: WIDTH]), 32'h5555);
    chk("mid_upper_unwritten", 32'(nodeWeight[N*WIDTH-1:10*WIDTH] == '0), 32'd1);
    do_clear();
    send_graph(g_small);
    check_small();
    do_clear();

    // asynchronous reset between clock edges in LOAD
    send_edge(6'd0, 6'd1, 1'b0);
    send_edge(6'd1, 6'd2, 1'b0);
    chk("pre_async_adj_ones", 32'($countones(adj)), 32'd2);
    #3;
    reset = 1'b0;
    #1;
    check_cleared("async_reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    send_graph(g_small);
    check_small();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
